// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG Huffman decoder: FSM states, table select
// codes and the JPEG symbol limits.
package jpeg_pkg;

  localparam int MAX_CODE_LEN = 16;
  localparam int DC_MAX_SIZE  = 11;
  localparam int AC_MAX_SIZE  = 10;

  localparam logic [7:0] SYM_EOB = 8'h00;
  localparam logic [7:0] SYM_ZRL = 8'hF0;

  localparam logic [1:0] SEL_MINCODE = 2'd0;
  localparam logic [1:0] SEL_COUNT   = 2'd1;
  localparam logic [1:0] SEL_VALPTR  = 2'd2;
  localparam logic [1:0] SEL_HUFFVAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CODE,
    ST_LOOKUP,
    ST_EXTRA,
    ST_OUT
  } dec_state_t;

endpackage

// File: rtl/jpeg_huff_table.sv
// Canonical Huffman table: per-length MINCODE/COUNT/VALPTR registers with a
// combinational lookup, plus the synchronous HUFFVAL symbol RAM.
module jpeg_huff_table #(
  parameter int HUFFVAL_DEPTH = 256
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [3:0]  len_idx,
  output logic [15:0] mincode,
  output logic [7:0]  count,
  output logic [7:0]  valptr,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data
);
  import jpeg_pkg::*;

  logic [15:0] mincode_q [16];
  logic [7:0]  count_q   [16];
  logic [7:0]  valptr_q  [16];
  logic [7:0]  huffval   [HUFFVAL_DEPTH];

  // Table contents are software-owned and intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_sel)
        SEL_MINCODE: mincode_q[wr_addr[3:0]] <= wr_data;
        SEL_COUNT:   count_q[wr_addr[3:0]]   <= wr_data[7:0];
        SEL_VALPTR:  valptr_q[wr_addr[3:0]]  <= wr_data[7:0];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_sel == SEL_HUFFVAL) begin
      huffval[wr_addr] <= wr_data[7:0];
    end
    rd_data <= huffval[rd_addr];
  end

  assign mincode = mincode_q[len_idx];
  assign count   = count_q[len_idx];
  assign valptr  = valptr_q[len_idx];

endmodule

// File: rtl/jpeg_huffman_decoder.sv
// Serial JPEG Huffman token decoder: matches one canonical code, fetches its
// magnitude bits and emits a (run, size, value) token.
module jpeg_huffman_decoder #(
  parameter int MAX_CODE_LEN  = 16,
  parameter int HUFFVAL_DEPTH = 256,
  parameter int VALUE_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dc_mode,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               tbl_wr_en,
  input  logic [1:0]         tbl_wr_sel,
  input  logic [7:0]         tbl_wr_addr,
  input  logic [15:0]        tbl_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_run,
  output logic [3:0]         out_size,
  output logic [VALUE_W-1:0] out_value,
  output logic               out_eob,
  output logic               err,
  output logic               busy
);
  import jpeg_pkg::*;

  dec_state_t  state;
  logic        dc_q;
  logic [14:0] code;
  logic [3:0]  len;
  logic [3:0]  cnt;
  logic [9:0]  raw;

  logic [15:0] ncode;
  logic [4:0]  nlen;
  logic [15:0] diff;
  logic        match;
  logic [10:0] nraw;
  logic [15:0] mincode;
  logic [7:0]  count;
  logic [7:0]  valptr;
  logic [7:0]  rd_addr;
  logic [7:0]  sym;
  logic        illegal;

  // JPEG EXTEND: a leading 0 marks a negative value offset by 2^size - 1.
  function automatic logic [VALUE_W-1:0] extend(input logic [10:0] v, input logic [3:0] s);
    logic [VALUE_W-1:0] wide;
    logic [VALUE_W-1:0] half;
    wide = VALUE_W'(v);
    half = VALUE_W'(1) << (s - 4'd1);
    if ((wide & half) != '0) return wide;
    return wide - ((half << 1) - VALUE_W'(1));
  endfunction

  assign ncode   = {code, bit_in};
  assign nlen    = {1'b0, len} + 5'd1;
  assign diff    = ncode - mincode;
  assign match   = (ncode >= mincode) && (diff < {8'd0, count});
  assign rd_addr = valptr + diff[7:0];
  assign nraw    = {raw, bit_in};
  assign illegal = dc_q ? (sym > 8'(DC_MAX_SIZE)) : (sym[3:0] > 4'(AC_MAX_SIZE));

  // The table is indexed by the length of the code including the incoming bit.
  jpeg_huff_table #(.HUFFVAL_DEPTH(HUFFVAL_DEPTH)) u_table (
    .clk     (clk),
    .wr_en   (tbl_wr_en && state == ST_IDLE),
    .wr_sel  (tbl_wr_sel),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data),
    .len_idx (len),
    .mincode (mincode),
    .count   (count),
    .valptr  (valptr),
    .rd_addr (rd_addr),
    .rd_data (sym)
  );

  assign bit_ready = (state == ST_CODE) || (state == ST_EXTRA);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dc_q      <= 1'b0;
      code      <= '0;
      len       <= '0;
      cnt       <= '0;
      raw       <= '0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_value <= '0;
      out_eob   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dc_q  <= dc_mode;
            code  <= '0;
            len   <= '0;
            state <= ST_CODE;
          end
        end
        ST_CODE: begin
          if (bit_valid) begin
            if (match) begin
              state <= ST_LOOKUP;
            end else if (nlen == 5'(MAX_CODE_LEN)) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              code <= ncode[14:0];
              len  <= nlen[3:0];
            end
          end
        end
        // The symbol read was launched on the matching bit, so sym is valid here.
        ST_LOOKUP: begin
          if (illegal) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            out_run  <= dc_q ? 4'd0 : sym[7:4];
            out_size <= sym[3:0];
            out_eob  <= !dc_q && (sym == SYM_EOB);
            raw      <= '0;
            cnt      <= sym[3:0];
            if (sym[3:0] == 4'd0) begin
              out_value <= '0;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              state <= ST_EXTRA;
            end
          end
        end
        ST_EXTRA: begin
          if (bit_valid) begin
            raw <= nraw[9:0];
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              out_value <= extend(nraw, out_size);
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
